// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the serial word link (receiver and transmitter).
//   rx_state_t : receiver FSM states (IDLE, RECV).
//   cnt_width  : width of a bit counter able to hold 0..w-1 with headroom,
//                i.e. $clog2(w)+1.
// -----------------------------------------------------------------------------
package serial_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/sipo_hold_reg.sv
// -----------------------------------------------------------------------------
// sipo_hold_reg
// One-entry valid/ready holding register for the serial receiver. A completed
// word is loaded when the slot is empty or is being emptied in the same cycle.
// Otherwise the new word is dropped, the held word is kept, and overrun pulses.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   load       in   one-cycle strobe: load_data holds a completed word
//   load_data  in   completed word
//   data_out   out  held word; keeps its last value when valid_out=0
//   valid_out  out  data_out holds an unconsumed word
//   ready_in   in   consumer takes data_out when valid_out & ready_in
//   overrun    out  registered one-cycle pulse: completed word was dropped
// -----------------------------------------------------------------------------
module sipo_hold_reg
#(
    parameter int DATA_WIDTH = 8
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic                  overrun
);

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: data_out is a single datapath register, not a memory, and
            // its reset value is visible on the port, so it is reset too.
            data_out  <= '0;
            valid_out <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load) begin
                // Slot is free now, or the consumer empties it on this edge.
                if (!valid_out || ready_in) begin
                    data_out  <= load_data;
                    valid_out <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid_out && ready_in) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sipo_rx.sv
// -----------------------------------------------------------------------------
// sipo_rx
// Serial-in, parallel-out receiver. Samples serial_in on every serial_valid
// cycle, assembles DATA_WIDTH-bit frames (LSB-first unless MSB_FIRST=1) and
// hands each completed word to a one-entry valid/ready holding register.
// A frame that loses serial_valid before its last bit is discarded and
// flagged with frame_err. Reception never stalls: backpressure only causes
// overrun.
//
// Parameters:
//   DATA_WIDTH  bits per word (>= 2)
//   MSB_FIRST   0: first serial bit is word bit 0; 1: word bit DATA_WIDTH-1
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   synchronous active-high reset
//   serial_in     in   serial data, sampled only when serial_valid=1
//   serial_valid  in   high for every cycle carrying a frame bit
//   data_out      out  received word, stable while valid_out=1
//   valid_out     out  data_out holds an unconsumed word
//   ready_in      in   consumer accepts data_out when valid_out & ready_in
//   busy          out  frame reception in progress (state RECV)
//   frame_err     out  one-cycle pulse: frame ended before DATA_WIDTH bits
//   overrun       out  one-cycle pulse: completed word dropped (slot full)
// -----------------------------------------------------------------------------
module sipo_rx
    import serial_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b0
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  serial_in,
    input  logic                  serial_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int               CNT_W    = cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    rx_state_t             state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_nxt;
    logic                  word_done;

    // Insert the new bit at the end opposite to the shift direction, so the
    // first bit ends up at bit 0 (LSB-first) or bit DATA_WIDTH-1 (MSB-first)
    // after exactly DATA_WIDTH shifts, with no final realignment.
    always_comb begin
        // NOTE: shift_nxt is assigned on every path, so no latch is inferred.
        shift_nxt = shift_reg;
        if (MSB_FIRST) begin
            shift_nxt = {shift_reg[DATA_WIDTH-2:0], serial_in};
        end else begin
            shift_nxt = {serial_in, shift_reg[DATA_WIDTH-1:1]};
        end
    end

    // word_done marks the cycle in which shift_reg holds a complete word. The
    // holding register samples shift_reg on the following edge, which is also
    // the edge that may shift in the first bit of a back-to-back frame; the
    // old (complete) value is what it sees.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples the pre-edge values of its inputs.
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            word_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            word_done <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (serial_valid) begin
                        shift_reg <= shift_nxt;
                        bit_cnt   <= CNT_W'(1);
                        state     <= RECV;
                    end
                end
                RECV: begin
                    if (serial_valid) begin
                        shift_reg <= shift_nxt;
                        if (bit_cnt == LAST_CNT) begin
                            bit_cnt   <= '0;
                            word_done <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else begin
                        // Short frame: the partial word is simply abandoned.
                        frame_err <= 1'b1;
                        bit_cnt   <= '0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    assign busy = (state == RECV);

    sipo_hold_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load      (word_done),
        .load_data (shift_reg),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .overrun   (overrun)
    );

endmodule

// File: tb/tb_sipo_rx.sv
// -----------------------------------------------------------------------------
// tb_sipo_rx
// Drives two receivers (LSB-first and MSB-first) with the same serial stream
// and compares both against a frame-level reference model every cycle:
// the model collects frame bits in a queue, builds the word arithmetically
// once DATA_WIDTH bits have arrived, and tracks the one-entry output slot.
// -----------------------------------------------------------------------------
module tb_sipo_rx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         serial_in;
    logic         serial_valid;
    logic         ready_in;

    logic [W-1:0] data_out_l, data_out_m;
    logic         valid_out_l, valid_out_m;
    logic         busy_l, busy_m;
    logic         frame_err_l, frame_err_m;
    logic         overrun_l, overrun_m;

    always #5 clk = ~clk;

    sipo_rx #(.DATA_WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .data_out     (data_out_l),
        .valid_out    (valid_out_l),
        .ready_in     (ready_in),
        .busy         (busy_l),
        .frame_err    (frame_err_l),
        .overrun      (overrun_l)
    );

    sipo_rx #(.DATA_WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .data_out     (data_out_m),
        .valid_out    (valid_out_m),
        .ready_in     (ready_in),
        .busy         (busy_m),
        .frame_err    (frame_err_m),
        .overrun      (overrun_m)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int           frame_q[$];     // bits of the frame in progress, in arrival order
    bit           pend;           // a word completed on the previous edge
    logic [W-1:0] pend_l, pend_m;
    bit           m_valid;
    logic [W-1:0] m_data_l, m_data_m;
    bit           m_ferr, m_ovr;

    task automatic model_step(input bit sv, input bit si, input bit rdy, input bit r);
        logic [W-1:0] wl, wm;
        if (r) begin
            frame_q.delete();
            pend     = 0;
            pend_l   = '0;
            pend_m   = '0;
            m_valid  = 0;
            m_data_l = '0;
            m_data_m = '0;
            m_ferr   = 0;
            m_ovr    = 0;
            return;
        end
        m_ferr = (frame_q.size() > 0) && !sv;
        m_ovr  = 0;
        // output slot: a completed word is offered one edge after its last bit
        if (pend) begin
            if (!m_valid || rdy) begin
                m_valid  = 1;
                m_data_l = pend_l;
                m_data_m = pend_m;
            end else begin
                m_ovr = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        pend = 0;
        if (sv) begin
            frame_q.push_back(int'(si));
            if (frame_q.size() == W) begin
                wl = '0;
                wm = '0;
                for (int i = 0; i < W; i++) begin
                    wl = wl + (W'(frame_q[i]) << i);
                    wm = wm + (W'(frame_q[i]) << (W - 1 - i));
                end
                pend   = 1;
                pend_l = wl;
                pend_m = wm;
                frame_q.delete();
            end
        end else begin
            frame_q.delete();
        end
    endtask

    function automatic bit m_busy();
        return frame_q.size() > 0;
    endfunction

    task automatic compare_all();
        check("valid_lsb", 32'(valid_out_l), 32'(m_valid));
        check("valid_msb", 32'(valid_out_m), 32'(m_valid));
        check("data_lsb",  32'(data_out_l),  32'(m_data_l));
        check("data_msb",  32'(data_out_m),  32'(m_data_m));
        check("busy_lsb",  32'(busy_l),      32'(m_busy()));
        check("busy_msb",  32'(busy_m),      32'(m_busy()));
        check("ferr_lsb",  32'(frame_err_l), 32'(m_ferr));
        check("ferr_msb",  32'(frame_err_m), 32'(m_ferr));
        check("ovr_lsb",   32'(overrun_l),   32'(m_ovr));
        check("ovr_msb",   32'(overrun_m),   32'(m_ovr));
    endtask

    // One clock: drive at the falling edge, let the rising edge happen,
    // compare at the next falling edge.
    task automatic tick(input bit sv, input bit si, input bit rdy, input bit r);
        serial_valid = sv;
        serial_in    = si;
        ready_in     = rdy;
        rst          = r;
        model_step(sv, si, rdy, r);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    // Send w bit 0 first over consecutive valid cycles.
    task automatic send_word(input logic [W-1:0] w, input bit rdy);
        for (int i = 0; i < W; i++) tick(1'b1, w[i], rdy, 1'b0);
    endtask

    task automatic idle(input bit rdy);
        tick(1'b0, 1'b0, rdy, 1'b0);
    endtask

    int busy_cnt;

    initial begin
        rst          = 1'b1;
        serial_valid = 1'b0;
        serial_in    = 1'b0;
        ready_in     = 1'b0;
        @(negedge clk);

        // reset state
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_data",  32'(data_out_l), 32'h0);
        check("rst_valid", 32'(valid_out_l), 32'h0);
        idle(1'b1);

        // 0xA5 LSB-first; busy spans the cycles after bits 1..W-1 are sampled
        busy_cnt = 0;
        for (int i = 0; i < W; i++) begin
            tick(1'b1, (8'hA5 >> i) & 1'b1, 1'b1, 1'b0);
            if (busy_l) busy_cnt++;
        end
        check("a5_busy_cycles", 32'(busy_cnt), 32'(W - 1));
        check("a5_not_yet_valid", 32'(valid_out_l), 32'h0);
        idle(1'b1);
        check("a5_valid", 32'(valid_out_l), 32'h1);
        check("a5_data",  32'(data_out_l),  32'hA5);
        idle(1'b1);
        check("a5_consumed", 32'(valid_out_l), 32'h0);

        // back-to-back 0x3C, 0xC3
        send_word(8'h3C, 1'b1);
        send_word(8'h3C ^ 8'hFF, 1'b1);
        idle(1'b1);
        check("b2b_second", 32'(data_out_l), 32'hC3);
        idle(1'b1);

        // short frame: 5 ones then drop valid
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        check("short_ferr", 32'(frame_err_l), 32'h1);
        check("short_novalid", 32'(valid_out_l), 32'h0);
        idle(1'b1);
        check("short_ferr_once", 32'(frame_err_l), 32'h0);
        send_word(8'h12, 1'b1);
        idle(1'b1);
        check("after_short", 32'(data_out_l), 32'h12);
        idle(1'b1);

        // overrun with ready low
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        idle(1'b0);
        check("ovr_pulse", 32'(overrun_l), 32'h1);
        check("ovr_keep",  32'(data_out_l), 32'h11);
        idle(1'b0);
        check("ovr_once",  32'(overrun_l), 32'h0);
        idle(1'b1);
        check("ovr_drain", 32'(valid_out_l), 32'h0);
        check("ovr_data_hold", 32'(data_out_l), 32'h11);

        // MSB-first patterns: serial 1,0,0,0,0,0,0,1 and 1,1,0,0,0,0,0,0
        send_word(8'h81, 1'b1);
        idle(1'b1);
        check("msb_81", 32'(data_out_m), 32'h81);
        send_word(8'h03, 1'b1);
        idle(1'b1);
        check("msb_c0", 32'(data_out_m), 32'hC0);
        check("lsb_03", 32'(data_out_l), 32'h03);
        idle(1'b1);

        // reset mid-frame with a word held
        send_word(8'h77, 1'b0);
        idle(1'b0);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        check("midrst_valid", 32'(valid_out_l), 32'h0);
        check("midrst_data",  32'(data_out_l),  32'h0);
        check("midrst_busy",  32'(busy_l),      32'h0);
        send_word(8'h5A, 1'b1);
        idle(1'b1);
        check("after_rst", 32'(data_out_l), 32'h5A);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            tick($urandom_range(0, 9) != 0,
                 1'($urandom),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 299) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
